// File: rtl/user_wb_timer.sv
// Wishbone timer/PWM slave: prescaled 32-bit down-counter with periodic or one-shot
// reload, sticky interrupt flag and compare-based PWM output.
module user_wb_timer #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned PRESC_W  = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o,
  output logic        pwm_o
);

  logic               r_en, r_oneshot, r_irq_en, r_out_en, r_flag, r_ack, r_pwm;
  logic [PRESC_W-1:0] r_presc, r_psc;
  logic [31:0]        r_reload, r_count, r_cmp, r_dat;

  logic        w_access, w_wr, w_wr_ctrl, w_wr_presc, w_wr_reload, w_wr_count;
  logic        w_wr_status, w_wr_cmp, w_en_rise, w_tick, w_event, w_unused;
  logic [2:0]  w_idx;
  logic [31:0] w_rdata, w_presc_ext, w_presc_new;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return res;
  endfunction

  // Holding off access while ack is high gives the single wait state and no back-to-back ack.
  assign w_access    = wbs_cyc_i && wbs_stb_i && !r_ack &&
                       (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  assign w_idx       = wbs_adr_i[4:2];
  assign w_wr        = w_access && wbs_we_i;
  assign w_wr_ctrl   = w_wr && (w_idx == 3'd0) && wbs_sel_i[0];
  assign w_wr_presc  = w_wr && (w_idx == 3'd1);
  assign w_wr_reload = w_wr && (w_idx == 3'd2);
  assign w_wr_count  = w_wr && (w_idx == 3'd3);
  assign w_wr_status = w_wr && (w_idx == 3'd4) && wbs_sel_i[0];
  assign w_wr_cmp    = w_wr && (w_idx == 3'd5);
  assign w_en_rise   = w_wr_ctrl && wbs_dat_i[0] && !r_en;

  assign w_presc_ext = 32'(r_presc);
  assign w_presc_new = merge_bytes(w_presc_ext, wbs_dat_i, wbs_sel_i);
  assign w_unused    = ^{wbs_adr_i[1:0], w_presc_new};

  assign w_tick  = r_en && (r_psc == r_presc);
  assign w_event = w_tick && (r_count == 32'd0);

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_flag && r_irq_en;
  assign pwm_o     = r_pwm;

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      3'd0:    w_rdata = {28'd0, r_out_en, r_irq_en, r_oneshot, r_en};
      3'd1:    w_rdata = w_presc_ext;
      3'd2:    w_rdata = r_reload;
      3'd3:    w_rdata = r_count;
      3'd4:    w_rdata = {31'd0, r_flag};
      3'd5:    w_rdata = r_cmp;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_access;
      r_dat <= (w_access && !wbs_we_i) ? w_rdata : '0;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_en      <= 1'b0;
      r_oneshot <= 1'b0;
      r_irq_en  <= 1'b0;
      r_out_en  <= 1'b0;
      r_flag    <= 1'b0;
      r_pwm     <= 1'b0;
      r_presc   <= '0;
      r_psc     <= '0;
      r_reload  <= '0;
      r_count   <= '0;
      r_cmp     <= '0;
    end else begin
      r_pwm <= r_en && r_out_en && (r_count < r_cmp);

      // A bus write to CTRL overrides the one-shot auto-disable.
      if (w_wr_ctrl)
        {r_out_en, r_irq_en, r_oneshot, r_en} <= wbs_dat_i[3:0];
      else if (w_event && r_oneshot)
        r_en <= 1'b0;

      if (w_wr_presc)  r_presc  <= w_presc_new[PRESC_W-1:0];
      if (w_wr_reload) r_reload <= merge_bytes(r_reload, wbs_dat_i, wbs_sel_i);
      if (w_wr_cmp)    r_cmp    <= merge_bytes(r_cmp, wbs_dat_i, wbs_sel_i);

      if (w_event)
        r_flag <= 1'b1;
      else if (w_wr_status && wbs_dat_i[0])
        r_flag <= 1'b0;

      if (w_wr_presc || w_en_rise || w_tick)
        r_psc <= '0;
      else if (r_en)
        r_psc <= r_psc + PRESC_W'(1);

      if (w_wr_count)
        r_count <= merge_bytes(r_count, wbs_dat_i, wbs_sel_i);
      else if (w_event)
        r_count <= r_oneshot ? 32'd0 : r_reload;
      else if (w_tick)
        r_count <= r_count - 32'd1;
    end
  end

endmodule

// File: tb/tb_user_wb_timer.sv
// Bench for user_wb_timer: directed scenarios plus randomized bus traffic, all
// checked every cycle against a register-array model of the timer.
module tb_user_wb_timer;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat = '0;
  logic        ack, irq, pwm;
  logic [31:0] dato;

  user_wb_timer #(.BASE_ADR(BASE), .PRESC_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(ack), .wbs_dat_o(dato), .irq_o(irq), .pwm_o(pwm)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0;
  int unsigned cyc_cnt = 0;
  bit          chk_on = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Model: index 0 CTRL, 1 PRESCALE, 2 RELOAD, 3 COUNT, 4 STATUS, 5 CMP, 6/7 always 0.
  logic [31:0] m_reg[8];
  int unsigned m_psc;
  logic        m_ack, m_pwm;
  logic [31:0] m_dat;

  function automatic logic [31:0] bytemask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_psc = 0; m_ack = 1'b0; m_pwm = 1'b0; m_dat = '0;
  endtask

  // Predicts the state after the coming rising edge from the inputs now on the bus.
  task automatic model_step();
    logic [31:0] nx[8];
    logic        acc, tick, evt, en;
    logic [2:0]  off;
    logic [31:0] msk;
    int unsigned psc_n;
    nx   = m_reg;
    off  = adr[4:2];
    en   = m_reg[0][0];
    acc  = cyc && stb && (adr[31:5] == BASE[31:5]) && !m_ack;
    tick = en && (m_psc == m_reg[1]);
    evt  = tick && (m_reg[3] == 0);
    if (tick) begin
      if (evt) begin
        nx[4] = 32'd1;
        if (m_reg[0][1]) nx[0][0] = 1'b0;
        else             nx[3] = m_reg[2];
      end else nx[3] = m_reg[3] - 1;
    end
    psc_n = !en ? m_psc : (tick ? 0 : m_psc + 1);
    if (acc && we) begin
      msk = bytemask(sel);
      case (off)
        3'd0: if (sel[0]) begin
                if (dat[0] && !en) psc_n = 0;
                nx[0] = dat & 32'hF;
              end
        3'd1: begin
                nx[1] = ((m_reg[1] & ~msk) | (dat & msk)) & 32'h0000_FFFF;
                psc_n = 0;
              end
        3'd2, 3'd3, 3'd5: nx[off] = (m_reg[off] & ~msk) | (dat & msk);
        3'd4: if (sel[0] && dat[0] && !evt) nx[4] = 32'd0;
        default: ;
      endcase
    end
    m_pwm = en && m_reg[0][3] && (m_reg[3] < m_reg[5]);
    m_dat = (acc && !we) ? m_reg[off] : 32'd0;
    m_ack = acc;
    m_psc = psc_n;
    m_reg = nx;
  endtask

  always @(negedge clk) begin
    if (rst) model_reset();
    if (chk_on) begin
      chk("ack",   32'(ack), 32'(m_ack));
      chk("dat_o", dato, m_dat);
      chk("irq",   32'(irq), 32'(m_reg[4][0] & m_reg[0][2]));
      chk("pwm",   32'(pwm), 32'(m_pwm));
    end
    if (!rst) model_step();
  end

  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] rd, output int unsigned t);
    int n;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    n = 0;
    do begin @(negedge clk); n++; end while (!ack && n < 8);
    chk("bus_ack", 32'(ack), 32'd1);
    rd = dato;
    t  = cyc_cnt;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    logic [31:0] r; int unsigned t;
    wb(1'b1, BASE + off, d, 4'hF, r, t);
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] v);
    int unsigned t;
    wb(1'b0, BASE + off, 32'd0, 4'hF, v, t);
  endtask

  task automatic wait_irq(input int limit);
    int n = 0;
    while (!irq && n < limit) begin @(negedge clk); n++; end
  endtask

  task automatic pwm_count(output int cnt);
    cnt = 0;
    repeat (3) @(negedge clk);
    repeat (20) begin @(negedge clk); cnt += int'(pwm); end
  endtask

  initial begin
    logic [31:0] v, a, d;
    int unsigned t0, t1, t3;
    int cnt;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; chk_on = 1'b1;

    // Reset state
    chk("T1_irq", 32'(irq), 32'd0);
    chk("T1_pwm", 32'(pwm), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(32'(i * 4), v);
      chk("T1_read_zero", v, 32'd0);
    end
    wr(32'h1C, 32'hFFFF_FFFF);
    rd(32'h1C, v);
    chk("T1_unused_reg", v, 32'd0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h20;
    repeat (4) begin @(negedge clk); chk("T1_nomatch_ack", 32'(ack), 32'd0); end
    @(posedge clk); #1; cyc = 1'b0; stb = 1'b0;

    // Periodic mode, period 4 clocks
    wr(32'h04, 0); wr(32'h08, 3); wr(32'h0C, 3); wr(32'h10, 1);
    wb(1'b1, BASE, 32'h5, 4'hF, v, t0);
    wait_irq(40);
    t1 = cyc_cnt;
    chk("T2_irq_set", 32'(irq), 32'd1);
    chk("T2_first_event", t1 - t0, 32'd4);
    wr(32'h10, 1);
    chk("T2_irq_cleared", 32'(irq), 32'd0);
    wait_irq(40);
    t3 = cyc_cnt;
    chk("T2_period", t3 - t1, 32'd4);

    // One-shot: (5+1)*(1+1) clocks
    wr(0, 0); wr(32'h04, 1); wr(32'h0C, 5); wr(32'h10, 1);
    wb(1'b1, BASE, 32'h7, 4'hF, v, t0);
    wait_irq(60);
    chk("T3_delay", cyc_cnt - t0, 32'd12);
    rd(0, v);     chk("T3_ctrl_en_off", v, 32'h6);
    rd(32'h0C, v); chk("T3_count_zero", v, 32'd0);
    wr(32'h10, 1);
    repeat (30) @(negedge clk);
    chk("T3_no_second_event", 32'(irq), 32'd0);

    // W1C landing on the event edge (writes commit every 3 clocks, events every 4)
    wr(0, 0); wr(32'h04, 0); wr(32'h08, 3); wr(32'h0C, 3); wr(32'h10, 1);
    wr(0, 5); wr(32'h14, 0); wr(32'h14, 0); wr(32'h14, 0); wr(32'h10, 1);
    rd(32'h10, v);
    chk("T4_w1c_vs_event", v, 32'd1);

    // COUNT write landing on a tick edge (PRESCALE=2 matches the 3-clock write cadence)
    wr(0, 0); wr(32'h04, 2); wr(32'h08, 32'h40); wr(32'h0C, 32'h50);
    wr(0, 1); wr(32'h0C, 32'h20);
    rd(32'h0C, v);
    chk("T4_count_write_wins", v, 32'h20);

    // PWM duty
    wr(0, 0); wr(32'h04, 0); wr(32'h08, 9); wr(32'h0C, 9); wr(32'h14, 3); wr(0, 9);
    pwm_count(cnt); chk("T5_duty_3of10", 32'(cnt), 32'd6);
    wr(32'h14, 0);
    pwm_count(cnt); chk("T5_cmp_zero", 32'(cnt), 32'd0);
    wr(32'h14, 100);
    pwm_count(cnt); chk("T5_cmp_above_reload", 32'(cnt), 32'd20);

    // Reset during count and during an ack
    wr(0, 0); wr(32'h10, 1); wr(32'h08, 9); wr(32'h14, 100); wr(0, 32'hD);
    repeat (15) @(negedge clk);
    chk("T6_irq_before", 32'(irq), 32'd1);
    chk("T6_pwm_before", 32'(pwm), 32'd1);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h0C;
    @(posedge clk); #2;
    chk("T6_ack_before", 32'(ack), 32'd1);
    rst = 1'b1;
    #1;
    chk("T6_ack_dropped", 32'(ack), 32'd0);
    chk("T6_dat_zero", dato, 32'd0);
    chk("T6_irq_zero", 32'(irq), 32'd0);
    chk("T6_pwm_zero", 32'(pwm), 32'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    rd(0, v);      chk("T6_ctrl_reset", v, 32'd0);
    rd(32'h0C, v); chk("T6_count_reset", v, 32'd0);
    rd(32'h10, v); chk("T6_status_reset", v, 32'd0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      int unsigned off;
      off = $urandom_range(0, 7);
      case (off)
        0:       d = $urandom & 32'hF;
        1:       d = $urandom_range(0, 3);
        2, 3:    d = $urandom_range(0, 12);
        4:       d = $urandom_range(0, 1);
        5:       d = $urandom_range(0, 14);
        default: d = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) begin
        a = BASE ^ (32'd1 << $urandom_range(5, 31));
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'($urandom_range(0, 1)); adr = a; dat = d;
        repeat (2) @(negedge clk);
        @(posedge clk); #1; cyc = 1'b0; stb = 1'b0;
      end else begin
        wb(1'($urandom_range(0, 1)), BASE + 32'(off * 4), d, 4'($urandom_range(0, 15)), v, t0);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
